// File: rtl/result_writer_pkg.sv
// rtl/result_writer_pkg.sv - shared widths, FSM encoding and helpers for the result writer
package result_writer_pkg;

  localparam int RES_W             = 18;
  localparam int RAM_DW            = 32;
  localparam int RES_PER_FRAME_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef logic [RES_W-1:0] res_t;
  // Index 0 holds MU1, index 3 holds MU4.
  typedef res_t [3:0] res_set_t;

  function automatic logic [RAM_DW-1:0] zext_res(input res_t r);
    return {{(RAM_DW-RES_W){1'b0}}, r};
  endfunction

endpackage

// File: rtl/result_pingpong.sv
// rtl/result_pingpong.sv - 2-entry result-set capture buffer, never back-pressures the producer
module result_pingpong
  import result_writer_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     web,
  input  res_set_t set_in,
  input  logic     rd_free,
  output logic [1:0] full,
  output logic     rd_sel,
  output res_set_t rd_set,
  output logic     drop
);

  res_set_t   mem [2];
  logic       wr_sel;
  logic       accept;
  logic [1:0] full_nxt;

  // Entries fill and drain in order, so the write slot is only busy when both are full;
  // a free strobe in the same cycle releases exactly that slot.
  assign accept = web && (!full[wr_sel] || rd_free);
  assign drop   = web && !accept;
  assign rd_set = mem[rd_sel];

  always_comb begin
    full_nxt = full;
    if (rd_free) full_nxt[rd_sel] = 1'b0;
    if (accept)  full_nxt[wr_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      full <= full_nxt;
      if (accept)  wr_sel <= ~wr_sel;
      if (rd_free) rd_sel <= ~rd_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_sel] <= set_in;
  end

endmodule

// File: rtl/result_writer.sv
// rtl/result_writer.sv - writes 4-row result sets to SRAM in frames; RESULT_MAX_EN adds max tracking
module result_writer
  import result_writer_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int RES_PER_FRAME = RES_PER_FRAME_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              web,
  input  logic [RES_W-1:0]  MU1,
  input  logic [RES_W-1:0]  MU2,
  input  logic [RES_W-1:0]  MU3,
  input  logic [RES_W-1:0]  MU4,
  input  logic              ALU_done,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_din,
  output logic              wr_done,
`ifdef RESULT_MAX_EN
  output logic [RES_W-1:0]  max_val,
  output logic [ADDR_W-1:0] max_addr,
`endif
  output logic              ovf_err
);

  logic [1:0]        state, state_nxt;
  logic [1:0]        beat;
  logic [ADDR_W-1:0] frame_base, result_idx, last_addr, cur_addr;
  logic [RAM_DW-1:0] last_din, cur_din;
  logic              done_pend;
  logic              writing, flushing, last_beat;
  logic [1:0]        full;
  logic              rd_sel, drop;
  res_set_t          rd_set;
  res_t              cur_res;

  result_pingpong u_pingpong (
    .clk     (clk),
    .rst     (rst),
    .web     (web),
    .set_in  ({MU4, MU3, MU2, MU1}),
    .rd_free (last_beat),
    .full    (full),
    .rd_sel  (rd_sel),
    .rd_set  (rd_set),
    .drop    (drop)
  );

  assign writing   = (state == ST_WRITE);
  assign flushing  = (state == ST_FLUSH);
  assign last_beat = writing && (beat == 2'd3);
  assign cur_res   = rd_set[beat];
  assign cur_addr  = frame_base + result_idx;
  assign cur_din   = zext_res(cur_res);

  // Strobes come straight from the state register so reset releases the SRAM asynchronously.
  assign ram_cen  = !writing;
  assign ram_wen  = !writing;
  assign ram_addr = writing ? cur_addr : last_addr;
  assign ram_din  = writing ? cur_din  : last_din;
  assign wr_done  = flushing;

  // A strobe this cycle already counts as a full entry, giving first-write latency of one.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (web || (|full))  state_nxt = ST_WRITE;
        else if (done_pend)  state_nxt = ST_FLUSH;
      end
      ST_WRITE: begin
        if (last_beat) begin
          if (full[~rd_sel] || web) state_nxt = ST_WRITE;
          else if (done_pend)       state_nxt = ST_FLUSH;
          else                      state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      beat       <= 2'd0;
      frame_base <= '0;
      result_idx <= '0;
      done_pend  <= 1'b0;
      last_addr  <= '0;
      last_din   <= '0;
      ovf_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat      <= writing ? beat + 2'd1 : 2'd0;
      done_pend <= (done_pend && !flushing) || ALU_done;
      ovf_err   <= ovf_err || drop;
      if (writing) begin
        last_addr  <= cur_addr;
        last_din   <= cur_din;
        result_idx <= (result_idx == ADDR_W'(RES_PER_FRAME - 1)) ? '0 : result_idx + 1'b1;
      end else if (flushing) begin
        result_idx <= '0;
        frame_base <= frame_base + ADDR_W'(RES_PER_FRAME);
      end
    end
  end

`ifdef RESULT_MAX_EN
  // Strict compare keeps the first occurrence on ties; the first write of a frame always loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_val  <= '0;
      max_addr <= '0;
    end else if (flushing) begin
      max_val  <= '0;
      max_addr <= '0;
    end else if (writing && ((result_idx == '0) || (cur_res > max_val))) begin
      max_val  <= cur_res;
      max_addr <= cur_addr;
    end
  end
`endif

endmodule

// File: tb/tb_result_writer.sv
// tb/tb_result_writer.sv - directed self-checking bench for result_writer
module tb_result_writer;
  import result_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, web, ALU_done;
  logic [17:0] MU1, MU2, MU3, MU4;
  logic        ram_cen, ram_wen, wr_done, ovf_err;
  logic [7:0]  ram_addr;
  logic [31:0] ram_din;
`ifdef RESULT_MAX_EN
  logic [17:0] max_val;
  logic [7:0]  max_addr;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] got_din[$];
  logic [7:0]  got_addr[$];
  int          wr_pulses;

  always #5 clk = ~clk;

  result_writer #(.ADDR_W(8), .RES_PER_FRAME(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .web      (web),
    .MU1      (MU1),
    .MU2      (MU2),
    .MU3      (MU3),
    .MU4      (MU4),
    .ALU_done (ALU_done),
    .ram_cen  (ram_cen),
    .ram_wen  (ram_wen),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .wr_done  (wr_done),
`ifdef RESULT_MAX_EN
    .max_val  (max_val),
    .max_addr (max_addr),
`endif
    .ovf_err  (ovf_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    web = 1'b0;
    ALU_done = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic set_mu(input logic [17:0] a, input logic [17:0] b, input logic [17:0] c, input logic [17:0] d);
    MU1 = a; MU2 = b; MU3 = c; MU4 = d;
  endtask

  function automatic logic [17:0] fval(input int idx);
    return (idx == 9) ? 18'h3FFFF : 18'(idx * 7 + 3);
  endfunction

  // Webs at the cycles flagged in mask; set from cycle i carries i*16+1 .. i*16+4.
  task automatic run_sched(input logic [31:0] mask, input int ncyc);
    got_din.delete();
    got_addr.delete();
    wr_pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      web = mask[i];
      set_mu(18'(i*16+1), 18'(i*16+2), 18'(i*16+3), 18'(i*16+4));
      cyc();
      if (ram_cen == 1'b0) begin
        got_din.push_back(ram_din);
        got_addr.push_back(ram_addr);
      end
      if (wr_done) wr_pulses++;
    end
    web = 1'b0;
  endtask

  task automatic check_set(input int slot, input int src_cycle);
    for (int k = 0; k < 4; k++) begin
      if (slot*4 + k < got_din.size()) begin
        check("sched_din", got_din[slot*4+k], 32'(src_cycle*16 + k + 1));
        check("sched_addr", got_addr[slot*4+k], 32'(slot*4 + k));
      end
    end
  endtask

  // Four sets spaced 8 cycles, ALU_done with the last one.
  task automatic run_frame(input logic [7:0] base);
    logic [7:0] a;
    for (int s = 0; s < 4; s++) begin
      web = 1'b1;
      ALU_done = (s == 3);
      set_mu(fval(s*4), fval(s*4+1), fval(s*4+2), fval(s*4+3));
      cyc();
      web = 1'b0;
      ALU_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
        a = base + 8'(s*4 + k);
        check("frame_cen", ram_cen, 0);
        check("frame_addr", ram_addr, a);
        check("frame_din", ram_din, 32'(fval(s*4+k)));
        check("frame_no_done", wr_done, 0);
        cyc();
      end
      if (s == 3) begin
        check("frame_wr_done", wr_done, 1);
        check("frame_flush_cen", ram_cen, 1);
`ifdef RESULT_MAX_EN
        check("max_val", max_val, 32'h3FFFF);
        check("max_addr", max_addr, base + 8'd9);
`endif
        cyc();
        check("frame_wr_done_pulse", wr_done, 0);
      end else begin
        repeat (3) cyc();
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    web = 1'b0;
    ALU_done = 1'b0;
    set_mu(0, 0, 0, 0);
    cyc();
    cyc();
    check("rst_cen", ram_cen, 1);
    check("rst_wen", ram_wen, 1);
    check("rst_addr", ram_addr, 0);
    check("rst_din", ram_din, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_ovf", ovf_err, 0);
    rst = 1'b1;
    cyc();

    // Single set, latency 1, then hold.
    web = 1'b1;
    set_mu(1, 2, 3, 4);
    cyc();
    web = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("single_cen", ram_cen, 0);
      check("single_wen", ram_wen, 0);
      check("single_addr", ram_addr, 32'(k));
      check("single_din", ram_din, 32'(k+1));
      cyc();
    end
    check("idle_cen", ram_cen, 1);
    check("idle_wen", ram_wen, 1);
    check("hold_addr", ram_addr, 3);
    check("hold_din", ram_din, 4);

    // Full frame, then next frame base.
    reset_dut();
    run_frame(8'd0);
    web = 1'b1;
    set_mu(5, 6, 7, 8);
    cyc();
    web = 1'b0;
    check("next_frame_addr", ram_addr, 16);
    check("next_frame_din", ram_din, 5);
    repeat (4) cyc();

    // Three consecutive sets: third dropped.
    reset_dut();
    run_sched(32'b111, 14);
    check("ovf_count", got_din.size(), 8);
    check_set(0, 0);
    check_set(1, 1);
    check("ovf_set", ovf_err, 1);
    repeat (3) cyc();
    check("ovf_sticky", ovf_err, 1);

    // Web on the freeing 4th write: accepted, no overflow.
    reset_dut();
    run_sched(32'b10011, 16);
    check("free_count", got_din.size(), 12);
    check_set(0, 0);
    check_set(1, 1);
    check_set(2, 4);
    check("free_no_ovf", ovf_err, 0);
    check("free_no_done", wr_pulses, 0);

    // Empty frames walk the base to 240, then wrap.
    reset_dut();
    wr_pulses = 0;
    for (int f = 0; f < 15; f++) begin
      ALU_done = 1'b1;
      cyc();
      ALU_done = 1'b0;
      for (int j = 0; j < 3; j++) begin
        cyc();
        if (wr_done) wr_pulses++;
      end
    end
    check("empty_frames", wr_pulses, 15);
    run_frame(8'd240);
    web = 1'b1;
    set_mu(33, 34, 35, 36);
    cyc();
    web = 1'b0;
    check("wrap_addr", ram_addr, 0);
    check("wrap_din", ram_din, 33);
    repeat (4) cyc();

    // Reset during the 2nd write.
    reset_dut();
    web = 1'b1;
    set_mu(9, 10, 11, 12);
    cyc();
    web = 1'b0;
    check("abort_w0_din", ram_din, 9);
    cyc();
    check("abort_w1_cen", ram_cen, 0);
    check("abort_w1_addr", ram_addr, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_cen", ram_cen, 1);
    check("abort_wen", ram_wen, 1);
    check("abort_wr_done", wr_done, 0);
    cyc();
    rst = 1'b1;
    cyc();
    web = 1'b1;
    set_mu(21, 22, 23, 24);
    cyc();
    web = 1'b0;
    check("post_abort_addr", ram_addr, 0);
    check("post_abort_din", ram_din, 21);
    repeat (5) cyc();
    check("post_abort_cen", ram_cen, 1);
    check("post_abort_no_done", wr_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter ADDR_W, default 8, meaning SRAM word-address width.
REQ-002 Parameter RES_PER_FRAME, default 16, meaning results per input matrix (4 per web strobe x 4 strobes).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 web  input  1  result-valid strobe: MU1..MU4 hold a complete 4-row dot-product set this cycle.
REQ-006 MU1, MU2, MU3, MU4  input  18 each  unsigned accumulated results, row 1..4.
REQ-007 ALU_done  input  1  one-cycle pulse: last result set of the matrix has been strobed.
REQ-008 ram_cen  output  1  SRAM chip enable, active-low.
REQ-009 ram_wen  output  1  SRAM write enable, active-low.
REQ-010 ram_addr  output  ADDR_W  SRAM word address.
REQ-011 ram_din  output  32  SRAM write data, result zero-extended from 18 to 32 bits.
REQ-012 wr_done  output  1  one-cycle pulse: all results of the frame are written.
REQ-013 ovf_err  output  1  sticky: a result set was lost.

Function
REQ-014 On web=1, MU1..MU4 SHALL be captured into a 2-entry ping-pong buffer in the same cycle; the capture is never back-pressured.
REQ-015 FSM states: IDLE, WRITE, FLUSH; IDLE->WRITE when at least one buffer entry is full; WRITE issues four consecutive writes (MU1, MU2, MU3, MU4 order), one per cycle, ram_cen=ram_wen=0 in each.
REQ-016 After the 4th write, WRITE->WRITE if the other entry is full, WRITE->FLUSH if a latched ALU_done is pending and both entries are empty, else WRITE->IDLE.
REQ-017 First write of a captured set SHALL occur the cycle after capture (latency 1).
REQ-018 Address = frame_base + result_idx, where result_idx counts 0..RES_PER_FRAME-1 and increments per write; addition wraps modulo 2^ADDR_W.
REQ-019 FLUSH lasts one cycle: wr_done=1, frame_base += RES_PER_FRAME (wrapping), result_idx cleared, pending ALU_done cleared, then IDLE.
REQ-020 ALU_done SHALL be latched; in IDLE with empty buffer and ALU_done pending, go directly to FLUSH.
REQ-021 web while both entries full: incoming set discarded, ovf_err set and held until reset.
REQ-022 web in the same cycle an entry is freed (4th write): the freed entry SHALL accept the new set; no overflow.
REQ-023 web and ALU_done in the same cycle: set captured and done latched; wr_done follows the last write of that set.
REQ-024 Outside write cycles ram_cen=ram_wen=1, ram_din and ram_addr hold last values.

Reset
REQ-025 While rst=0: FSM IDLE, buffer empty, frame_base=0, result_idx=0, pending done=0, ram_cen=1, ram_wen=1, ram_addr=0, ram_din=0, wr_done=0, ovf_err=0.
REQ-026 Reset asserted mid-write aborts the set immediately; ram_cen/ram_wen go high asynchronously; no partial frame is reported.

Configuration
REQ-027 Macro RESULT_MAX_EN: when defined, outputs max_val (18) and max_addr (ADDR_W) SHALL track the largest result written in the current frame (first occurrence on ties), valid with wr_done and cleared to 0 in the FLUSH cycle; when undefined these ports and their logic are absent and all other behaviour is unchanged.

Structure
REQ-028 Shared package holds FSM state encoding (IDLE/WRITE/FLUSH), result width 18, RAM data width 32 and RES_PER_FRAME default.
REQ-029 One sub-module, result_pingpong, implements the 2-entry capture buffer (full flags, read select, free strobe); FSM and address generation stay in result_writer.

Verification
REQ-030 After reset, single web with MU1..4=1,2,3,4 -> writes at addr 0..3 with ram_din 1,2,3,4 in cycles 1..4 after the strobe.
REQ-031 Four webs spaced 8 cycles, ALU_done with the 4th -> 16 writes at addr 0..15, wr_done one cycle after the last write; next frame starts at addr 16.
REQ-032 Three webs on consecutive cycles -> first two sets written (8 writes), third discarded, ovf_err=1 and sticky.
REQ-033 Base 240, 16-result frame -> addresses 240..255, next frame base wraps to 0.
REQ-034 rst pulled low during the 2nd write of a set -> ram_cen/ram_wen high immediately; after release, fresh web writes at addr 0.
REQ-035 With RESULT_MAX_EN, frame values including 18'h3FFFF at result 9 -> max_val=18'h3FFFF, max_addr=frame_base+9 at wr_done.
